// File: rtl/apb_gpio.sv
// APB-attached GPIO block: output data with set/clear/toggle aliases, direction,
// synchronised inputs and rising-edge interrupts with write-1-to-clear status.
module apb_gpio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0080,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      paddr,
  input  logic             pwrite,
  input  logic             psel,
  input  logic             penable,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Handshake: a transfer is a setup cycle (psel=1, penable=0), then access
  // cycles with psel=penable=1; the block answers with pready=1 for exactly one
  // cycle (ACK) after one wait cycle, and the access completes on that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (psel && !penable) state_d = ST_WAIT;
      ST_WAIT: state_d = (psel && penable) ? ST_ACK : ST_IDLE;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Access attributes captured on entry to ACK so ACK does not depend on the bus.
  logic        hit_q;
  logic        wr_q;
  logic [2:0]  off_q;
  logic [31:0] wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q   <= 1'b0;
      wr_q    <= 1'b0;
      off_q   <= 3'd0;
      wdata_q <= 32'd0;
    end else if (state_q == ST_WAIT && psel && penable) begin
      hit_q   <= (paddr[31:5] == BASE_ADDR[31:5]);
      wr_q    <= pwrite;
      off_q   <= paddr[4:2];
      wdata_q <= pwdata;
    end
  end

  logic             ack;
  logic             err;
  logic             do_wr;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] clr_mask;

  assign ack   = (state_q == ST_ACK);
  assign err   = !hit_q || (wr_q && off_q == 3'd5);
  assign do_wr = ack && wr_q && !err;
  assign wmask = wdata_q[WIDTH-1:0];
  assign clr_mask = (do_wr && off_q == 3'd7) ? wmask : '0;

  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= RESET_VAL[WIDTH-1:0];
      dir_q      <= '0;
      irq_en_q   <= '0;
    end else if (do_wr) begin
      case (off_q)
        3'd0:    data_out_q <= wmask;
        3'd1:    data_out_q <= data_out_q | wmask;
        3'd2:    data_out_q <= data_out_q & ~wmask;
        3'd3:    data_out_q <= data_out_q ^ wmask;
        3'd4:    dir_q      <= wmask;
        3'd6:    irq_en_q   <= wmask;
        default: ;
      endcase
    end
  end

  // Input synchroniser; the last stage is the architectural DATA_IN.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= data_in;
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];
  assign rise    = data_in & ~prev_q;

  // A fresh edge on a bit being cleared in the same cycle keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_stat_q <= '0;
    else       irq_stat_q <= (irq_stat_q & ~clr_mask) | rise;
  end

  logic [WIDTH-1:0] rd_reg;

  always_comb begin
    rd_reg = '0;
    case (off_q)
      3'd0:    rd_reg = data_out_q;
      3'd4:    rd_reg = dir_q;
      3'd5:    rd_reg = data_in;
      3'd6:    rd_reg = irq_en_q;
      3'd7:    rd_reg = irq_stat_q;
      default: rd_reg = '0;
    endcase
  end

  always_comb begin
    prdata = '0;
    if (ack && hit_q) prdata[WIDTH-1:0] = rd_reg;
  end

  assign pready   = ack;
  assign pslverr  = ack && err;
  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(irq_stat_q & irq_en_q);

  // Byte-lane bits of the address and write data above WIDTH carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], wdata_q};

endmodule

// File: tb/tb_apb_gpio.sv
// Directed and randomised checks of apb_gpio against a register/pin-history model.
module tb_apb_gpio;

  localparam int          WIDTH = 8;
  localparam int          S     = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] RV    = 32'h0000_0080;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      paddr;
  logic             pwrite;
  logic             psel;
  logic             penable;
  logic [31:0]      pwdata;
  logic [31:0]      prdata;
  logic             pready;
  logic             pslverr;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  always #5 clk = ~clk;

  apb_gpio #(
    .WIDTH(WIDTH), .BASE_ADDR(BASE), .RESET_VAL(RV), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: register contents plus the history of pin values seen at each edge.
  logic [WIDTH-1:0] m_out, m_dir, m_en, m_stat, pend_clr;
  logic [WIDTH-1:0] pin_q[$];
  logic [WIDTH-1:0] m_rise;

  function automatic logic [WIDTH-1:0] m_din();
    return pin_q[pin_q.size()-S];
  endfunction

  function automatic logic m_irq();
    return |(m_stat & m_en);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_q = {};
      for (int i = 0; i < S + 2; i++) pin_q.push_back('0);
      m_stat   = '0;
      pend_clr = '0;
    end else if (pin_q.size() >= S + 2) begin
      m_rise   = pin_q[pin_q.size()-S] & ~pin_q[pin_q.size()-S-1];
      m_stat   = (m_stat & ~pend_clr) | m_rise;
      pend_clr = '0;
      pin_q.push_back(gpio_in);
      void'(pin_q.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return 32'(m_out);
      3'd4:    return 32'(m_dir);
      3'd5:    return 32'(m_din());
      3'd6:    return 32'(m_en);
      3'd7:    return 32'(m_stat);
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the transfer completed.
  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    logic             hit;
    logic [2:0]       off;
    logic             exp_err;
    logic [31:0]      exp_rd;
    logic [WIDTH-1:0] d;
    hit = (addr[31:5] == BASE[31:5]);
    off = addr[4:2];
    d   = wdata[WIDTH-1:0];
    paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    chk("pready_wait", 32'(pready), 32'd0);
    penable = 1'b1;
    @(negedge clk);
    exp_err = !hit || (wr && off == 3'd5);
    exp_rd  = hit ? model_read(off) : 32'd0;
    chk("pready_ack", 32'(pready), 32'd1);
    chk("pslverr_ack", 32'(pslverr), 32'(exp_err));
    chk("prdata_ack", prdata, exp_rd);
    chk("irq_ack", 32'(irq), 32'(m_irq()));
    if (wr && !exp_err) begin
      case (off)
        3'd0:    m_out = d;
        3'd1:    m_out = m_out | d;
        3'd2:    m_out = m_out & ~d;
        3'd3:    m_out = m_out ^ d;
        3'd4:    m_dir = d;
        3'd6:    m_en  = d;
        3'd7:    pend_clr = d;
        default: ;
      endcase
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    chk("pready_idle", 32'(pready), 32'd0);
    chk("pslverr_idle", 32'(pslverr), 32'd0);
    chk("prdata_idle", prdata, 32'd0);
    chk("gpio_out", 32'(gpio_out), 32'(m_out));
    chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    chk("irq", 32'(irq), 32'(m_irq()));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_out = RV[WIDTH-1:0];
    m_dir = '0;
    m_en  = '0;
  endtask

  logic [31:0] raddr;
  logic [2:0]  roff;

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpio_in = '0;
    model_reset();
    cycles(3);
    chk("rst_gpio_out", 32'(gpio_out), 32'h80);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    reset = 1'b0;
    cycles(1);

    // Reset value readback and output aliases.
    apb(BASE, 1'b0, 32'd0);
    apb(BASE + 32'h10, 1'b1, 32'hFF);
    apb(BASE + 32'h04, 1'b1, 32'h01);
    chk("set_out", 32'(gpio_out), 32'h81);
    apb(BASE + 32'h08, 1'b1, 32'h80);
    chk("clr_out", 32'(gpio_out), 32'h01);
    apb(BASE + 32'h0C, 1'b1, 32'h03);
    chk("tgl_out", 32'(gpio_out), 32'h02);
    chk("dir_oe", 32'(gpio_oe), 32'hFF);

    // Decode miss and DATA_IN write are errors with no side effect.
    apb(32'h8000_0020, 1'b0, 32'd0);
    apb(32'h8000_0020, 1'b1, 32'h55);
    apb(BASE + 32'h14, 1'b1, 32'hFF);
    chk("err_out", 32'(gpio_out), 32'h02);
    apb(BASE + 32'h10, 1'b0, 32'd0);

    // Byte-lane address bits ignored, data above WIDTH ignored.
    apb(BASE + 32'h03, 1'b1, 32'h5A);
    chk("lane_out", 32'(gpio_out), 32'h5A);
    apb(BASE, 1'b1, 32'hFFFF_FF3C);
    chk("wide_out", 32'(gpio_out), 32'h3C);
    apb(BASE, 1'b0, 32'd0);

    // Abandoned access: psel dropped during the wait state.
    paddr = BASE; pwrite = 1'b1; pwdata = 32'h11; psel = 1'b1; penable = 1'b0;
    cycles(1);
    psel = 1'b0;
    cycles(1);
    chk("abandon_pready1", 32'(pready), 32'd0);
    cycles(1);
    chk("abandon_pready2", 32'(pready), 32'd0);
    chk("abandon_out", 32'(gpio_out), 32'h3C);

    // Edge interrupt latency, clear, and set-beats-clear.
    apb(BASE + 32'h18, 1'b1, 32'h04);
    gpio_in = 8'h04;
    cycles(1);
    chk("irq_edge1", 32'(irq), 32'd0);
    cycles(1);
    chk("irq_edge2", 32'(irq), 32'd0);
    cycles(1);
    chk("irq_edge3", 32'(irq), 32'd1);
    apb(BASE + 32'h1C, 1'b0, 32'd0);
    apb(BASE + 32'h1C, 1'b1, 32'h04);
    chk("irq_cleared", 32'(irq), 32'd0);
    gpio_in = 8'h00;
    cycles(4);
    gpio_in = 8'h04;
    cycles(4);
    chk("irq_reraise", 32'(irq), 32'd1);
    gpio_in = 8'h00;
    cycles(4);
    gpio_in = 8'h04;
    apb(BASE + 32'h1C, 1'b1, 32'h04);
    chk("irq_set_wins", 32'(irq), 32'd1);
    apb(BASE + 32'h1C, 1'b0, 32'd0);

    // Reset during the wait state.
    paddr = BASE; pwrite = 1'b1; pwdata = 32'h77; psel = 1'b1; penable = 1'b0;
    cycles(1);
    penable = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("wrst_gpio_out", 32'(gpio_out), 32'h80);
    chk("wrst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("wrst_irq", 32'(irq), 32'd0);
    chk("wrst_pready", 32'(pready), 32'd0);
    chk("wrst_pslverr", 32'(pslverr), 32'd0);
    chk("wrst_prdata", prdata, 32'd0);
    cycles(1);
    reset = 1'b0;
    cycles(1);
    chk("post_rst_pready1", 32'(pready), 32'd0);
    cycles(1);
    chk("post_rst_pready2", 32'(pready), 32'd0);
    chk("post_rst_out", 32'(gpio_out), 32'h80);
    psel = 1'b0; penable = 1'b0;
    cycles(2);
    apb(BASE + 32'h1C, 1'b0, 32'd0);

    // Randomised register traffic with changing pins.
    for (int it = 0; it < 60; it++) begin
      gpio_in = WIDTH'($urandom);
      roff    = 3'($urandom_range(0, 7));
      raddr   = BASE + {27'd0, roff, 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) raddr = raddr + 32'h20 * 32'($urandom_range(1, 7));
      apb(raddr, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 4));
      apb(BASE + {27'd0, 3'($urandom_range(0, 7)), 2'b00}, 1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_gpio.md
APB_GPIO -- requirements
Module: apb_gpio

Interface
REQ-001 Parameters (name, default, meaning):
- WIDTH, 8: number of GPIO channels, 1..32.
- BASE_ADDR, 32'h80000000: base of the 32-byte register window; bits [4:0] are zero.
- RESET_VAL, 32'h80: reset value of DATA_OUT; only bits [WIDTH-1:0] are used.
- SYNC_STAGES, 2: input synchroniser depth, minimum 2.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock for all logic.
- reset, in, 1: asynchronous, active-high reset.
- paddr, in, 32: APB address.
- pwrite, in, 1: APB write strobe.
- psel, in, 1: APB select.
- penable, in, 1: APB enable.
- pwdata, in, 32: APB write data.
- prdata, out, 32: APB read data.
- pready, out, 1: APB ready.
- pslverr, out, 1: APB error.
- gpio_in, in, WIDTH: asynchronous pin inputs.
- gpio_out, out, WIDTH: pin output values.
- gpio_oe, out, WIDTH: output enables; 1 = drive.
- irq, out, 1: level interrupt.

Function
REQ-003 Register map (byte offset from BASE_ADDR):
- 0x00 DATA_OUT: read/write.
- 0x04 SET: write-only; each 1 bit sets the matching DATA_OUT bit.
- 0x08 CLR: write-only; each 1 bit clears the matching DATA_OUT bit.
- 0x0C TGL: write-only; each 1 bit inverts the matching DATA_OUT bit.
- 0x10 DIR: read/write; drives gpio_oe.
- 0x14 DATA_IN: read-only; synchronised gpio_in.
- 0x18 IRQ_EN: read/write.
- 0x1C IRQ_STAT: read, write-1-to-clear.

REQ-004 Address decode: a hit is paddr[31:5]==BASE_ADDR[31:5]; paddr[1:0] is ignored.
REQ-005 Handshake FSM has three states, IDLE, WAIT and ACK; each APB access inserts exactly one wait state.
REQ-006 FSM transitions:
- IDLE -> WAIT when psel=1 and penable=0.
- WAIT -> ACK when psel=1 and penable=1; WAIT -> IDLE otherwise (access abandoned, no side effect).
- ACK -> IDLE unconditionally.
REQ-007 pready=1 only in ACK; a transfer completes in the third cycle after setup.
REQ-008 Writes commit on the clk edge ending ACK; gpio_out/gpio_oe show the new value in the following cycle.
REQ-009 prdata in ACK = addressed register, zero-extended above WIDTH; write-only registers read 0; prdata=0 outside ACK.
REQ-010 pslverr=1 in ACK for a decode miss or a write to DATA_IN; such a write has no effect; pslverr=0 outside ACK.
REQ-011 Write data bits at or above WIDTH are ignored.
REQ-012 DATA_IN path: gpio_in passes through SYNC_STAGES flops; DATA_IN is the last stage.
REQ-013 IRQ_STAT[i] sets on a rising edge of DATA_IN[i] (current=1, previous=0), regardless of IRQ_EN.
REQ-014 Same-cycle IRQ_STAT set and write-1-clear on one bit: set wins.
REQ-015 irq = OR over i of (IRQ_STAT[i] AND IRQ_EN[i]); combinational from registers, no further delay.
REQ-016 Pin latency: a gpio_in change reaches DATA_IN after SYNC_STAGES edges and IRQ_STAT one edge later.

Reset
REQ-017 reset asserted, asynchronously:
- FSM -> IDLE.
- DATA_OUT=RESET_VAL[WIDTH-1:0]; DIR=0; IRQ_EN=0; IRQ_STAT=0.
- Synchroniser and edge-history flops = 0.
- pready=0; pslverr=0; prdata=0; irq=0.
REQ-018 reset asserted mid-transfer aborts the transfer: no register is modified, and pready stays 0 until a new setup phase.
REQ-019 After reset deasserts, the first rising edge of gpio_in is detected only after SYNC_STAGES+1 edges; a pin already high at reset release produces an edge.

Verification
REQ-020 Reset, then read 0x00 -> pready in cycle 3, prdata=32'h80, pslverr=0; gpio_oe=0.
REQ-021 Write DIR=0xFF, SET=0x01, CLR=0x80, TGL=0x03 -> gpio_out sequence 0x81, 0x01, 0x02; gpio_oe=0xFF.
REQ-022 Access paddr=0x80000020, then write 0x14 -> pslverr=1 with pready both times; no register changes.
REQ-023 IRQ_EN=0x04, raise gpio_in[2] -> IRQ_STAT=0x04 and irq=1 after 3 edges; write IRQ_STAT=0x04 -> irq=0; a new edge in the same cycle as the clear keeps irq=1.
REQ-024 psel deasserted in WAIT -> no pready, no state change; reset asserted in WAIT -> outputs at reset values immediately.
